// File: rtl/dmem_lsu_bridge_pkg.sv
// rtl/dmem_lsu_bridge_pkg.sv - shared types and lane helpers for the data-memory load/store bridge
package dmem_pkg;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_X = 2'd3} size_e;
  typedef enum logic [1:0] {EMPTY = 2'd0, RESP = 2'd1, HOLD = 2'd2} state_e;

  function automatic logic [3:0] byteena_f(input size_e size, input logic [1:0] off);
    case (size)
      SZ_B:    byteena_f = 4'b0001 << off;
      SZ_H:    byteena_f = 4'b0011 << off;
      default: byteena_f = 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data across all lanes so byteena alone selects the target bytes.
  function automatic logic [31:0] repl_f(input size_e size, input logic [31:0] wdata);
    case (size)
      SZ_B:    repl_f = {4{wdata[7:0]}};
      SZ_H:    repl_f = {2{wdata[15:0]}};
      default: repl_f = wdata;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_bridge_if.sv
// rtl/dmem_lsu_bridge_if.sv - core request/response channel and SRAM port interfaces
interface dmem_core_if import dmem_pkg::*; #(parameter int ADDR_W = 12);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W+1:0] req_addr;
  logic              req_we;
  size_e             req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface dmem_sram_if #(parameter int ADDR_W = 12);
  logic              mem_en;
  logic              mem_wren;
  logic [3:0]        mem_byteena;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_q;

  modport master (
    output mem_en, mem_wren, mem_byteena, mem_addr, mem_wdata,
    input  mem_q
  );
  modport slave (
    input  mem_en, mem_wren, mem_byteena, mem_addr, mem_wdata,
    output mem_q
  );
endinterface

// File: rtl/dmem_lsu_bridge_load_align.sv
// rtl/dmem_lsu_bridge_load_align.sv - lane shift and sign/zero extension of SRAM read data
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] mem_q,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  always_comb begin
    shifted = mem_q >> {off, 3'b000};
    case (size)
      SZ_B:    rdata = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_H:    rdata = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: rdata = mem_q;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_bridge.sv
// rtl/dmem_lsu_bridge.sv - load/store adapter to SRAM port B; DMEM_ERR_EN enables alignment/size errors
module dmem_lsu_bridge
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  dmem_core_if.slave  core,
  dmem_sram_if.master sram
);

  if (DATA_W != 32) begin : g_data_w_check
    $error("dmem_lsu_bridge: DATA_W must be 32");
  end

  localparam logic [1:0] S_EMPTY = EMPTY;
  localparam logic [1:0] S_RESP  = RESP;
  localparam logic [1:0] S_HOLD  = HOLD;

  logic [1:0]  state, state_nxt;
  logic        req_ready, accept, req_err;
  logic [1:0]  off, eff_off;
  size_e       eff_size;
  size_e       r_size;
  logic [1:0]  r_off;
  logic        r_unsigned, r_we, r_err;
  logic [31:0] aligned, fmt_rdata, h_rdata;
  logic        fmt_err, h_err;

  always_comb begin
    off = core.req_addr[1:0];
`ifdef DMEM_ERR_EN
    eff_size = core.req_size;
    eff_off  = off;
    req_err  = (core.req_size == SZ_X) |
               ((core.req_size == SZ_H) & off[0]) |
               ((core.req_size == SZ_W) & (off != 2'd0));
`else
    eff_size = (core.req_size == SZ_X) ? SZ_W : core.req_size;
    eff_off  = (eff_size == SZ_W) ? 2'd0 : (eff_size == SZ_H) ? {off[1], 1'b0} : off;
    req_err  = 1'b0;
`endif
  end

  // Combinational ready lets a new access issue in the same cycle the previous response drains.
  assign req_ready      = (state == S_EMPTY) | core.rsp_ready;
  assign accept         = core.req_valid & req_ready;
  assign core.req_ready = req_ready;

  assign sram.mem_en      = accept & ~req_err;
  assign sram.mem_wren    = accept & ~req_err & core.req_we;
  assign sram.mem_byteena = byteena_f(eff_size, eff_off);
  assign sram.mem_addr    = core.req_addr[ADDR_W+1:2];
  assign sram.mem_wdata   = repl_f(eff_size, core.req_wdata);

  dmem_load_align u_load_align (
    .mem_q       (sram.mem_q),
    .off         (r_off),
    .size        (r_size),
    .is_unsigned (r_unsigned),
    .rdata       (aligned)
  );

  assign fmt_rdata = (r_we | r_err) ? 32'd0 : aligned;
  assign fmt_err   = r_err;

  assign core.rsp_valid = (state != S_EMPTY);
  assign core.rsp_rdata = (state == S_HOLD) ? h_rdata : (state == S_RESP) ? fmt_rdata : 32'd0;
  assign core.rsp_err   = (state == S_HOLD) ? h_err   : (state == S_RESP) & fmt_err;

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: state_nxt = accept ? S_RESP : S_EMPTY;
      default: begin
        if (core.rsp_ready) state_nxt = accept ? S_RESP : S_EMPTY;
        else                state_nxt = S_HOLD;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_EMPTY;
      r_size     <= SZ_B;
      r_off      <= 2'd0;
      r_unsigned <= 1'b0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      h_rdata    <= 32'd0;
      h_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        r_size     <= eff_size;
        r_off      <= eff_off;
        r_unsigned <= core.req_unsigned;
        r_we       <= core.req_we;
        r_err      <= req_err;
      end
      // mem_q is only valid for one cycle, so a stalled response must be captured here.
      if ((state == S_RESP) && !core.rsp_ready) begin
        h_rdata <= fmt_rdata;
        h_err   <= fmt_err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu_bridge.sv
// tb/tb_dmem_lsu_bridge.sv - directed self-checking bench for dmem_lsu_bridge
module tb_dmem_lsu_bridge;
  import dmem_pkg::*;

  localparam int ADDR_W = 12;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   resp_cnt;
  int   cnt0;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] q;

  dmem_core_if #(.ADDR_W(ADDR_W)) core ();
  dmem_sram_if #(.ADDR_W(ADDR_W)) sram ();

  dmem_lsu_bridge #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .core    (core.slave),
    .sram    (sram.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read data is only meaningful the cycle after a read; other cycles show a marker pattern.
  always @(posedge clk) begin
    if (sram.mem_en) begin
      if (sram.mem_wren) begin
        for (int b = 0; b < 4; b++)
          if (sram.mem_byteena[b]) mem[sram.mem_addr][8*b +: 8] <= sram.mem_wdata[8*b +: 8];
        q <= 32'h5A5A5A5A;
      end else begin
        q <= mem[sram.mem_addr];
      end
    end else begin
      q <= 32'h5A5A5A5A;
    end
  end
  assign sram.mem_q = q;

  always @(posedge clk)
    if (reset_n && core.rsp_valid && core.rsp_ready) resp_cnt <= resp_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [13:0] addr, input logic we, input size_e size,
                       input logic uns, input logic [31:0] wdata);
    core.req_valid    = 1'b1;
    core.req_addr     = addr;
    core.req_we       = we;
    core.req_size     = size;
    core.req_unsigned = uns;
    core.req_wdata    = wdata;
    #1;
  endtask

  task automatic idle();
    core.req_valid = 1'b0;
    core.req_we    = 1'b0;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resp_cnt = 0;
    q        = 32'd0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hA500_0000 | i;
    reset_n           = 1'b0;
    core.rsp_ready    = 1'b1;
    core.req_addr     = '0;
    core.req_size     = SZ_W;
    core.req_unsigned = 1'b0;
    core.req_wdata    = '0;
    idle();
    tick();
    tick();
    check("rst_rsp_valid", 32'(core.rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(core.rsp_err),   32'd0);
    check("rst_rsp_rdata", core.rsp_rdata,      32'd0);
    check("rst_mem_en",    32'(sram.mem_en),    32'd0);
    reset_n = 1'b1;
    tick();

    issue(14'h010, 1'b1, SZ_W, 1'b0, 32'hDEADBEEF);
    check("sw_mem_en",   32'(sram.mem_en),      32'd1);
    check("sw_wren",     32'(sram.mem_wren),    32'd1);
    check("sw_byteena",  32'(sram.mem_byteena), 32'hF);
    check("sw_addr",     32'(sram.mem_addr),    32'd4);
    check("sw_wdata",    sram.mem_wdata,        32'hDEADBEEF);
    tick();
    check("sw_rsp_valid", 32'(core.rsp_valid), 32'd1);
    check("sw_rsp_rdata", core.rsp_rdata,      32'd0);
    issue(14'h010, 1'b0, SZ_W, 1'b0, 32'd0);
    check("lw_wren", 32'(sram.mem_wren), 32'd0);
    check("lw_addr", 32'(sram.mem_addr), 32'd4);
    tick();
    check("lw_rdata", core.rsp_rdata, 32'hDEADBEEF);

    issue(14'h013, 1'b1, SZ_B, 1'b0, 32'h00000080);
    check("sb_byteena", 32'(sram.mem_byteena), 32'h8);
    check("sb_wdata",   sram.mem_wdata,        32'h80808080);
    tick();
    issue(14'h013, 1'b0, SZ_B, 1'b0, 32'd0);
    tick();
    check("lb_signed", core.rsp_rdata, 32'hFFFFFF80);
    issue(14'h013, 1'b0, SZ_B, 1'b1, 32'd0);
    tick();
    check("lbu", core.rsp_rdata, 32'h00000080);

    issue(14'h042, 1'b1, SZ_H, 1'b0, 32'h0000BEEF);
    check("sh_byteena", 32'(sram.mem_byteena), 32'hC);
    check("sh_wdata",   sram.mem_wdata,        32'hBEEFBEEF);
    tick();
    issue(14'h010, 1'b1, SZ_W, 1'b0, 32'h80011234);
    tick();
    issue(14'h012, 1'b0, SZ_H, 1'b0, 32'd0);
    tick();
    check("lh_signed", core.rsp_rdata, 32'hFFFF8001);
    issue(14'h010, 1'b0, SZ_H, 1'b1, 32'd0);
    tick();
    check("lhu", core.rsp_rdata, 32'h00001234);
    issue(14'h040, 1'b0, SZ_W, 1'b0, 32'd0);
    tick();
    check("lw_after_sh", core.rsp_rdata, 32'hBEEF0010);
    idle();
    tick();
    check("idle_rsp_valid", 32'(core.rsp_valid), 32'd0);

    issue(14'h010, 1'b0, SZ_W, 1'b0, 32'd0);
    tick();
    core.rsp_ready = 1'b0;
    issue(14'h000, 1'b0, SZ_W, 1'b0, 32'd0);
    cnt0 = resp_cnt;
    check("stall_req_ready", 32'(core.req_ready), 32'd0);
    check("stall_mem_en",    32'(sram.mem_en),    32'd0);
    check("stall_rdata",     core.rsp_rdata,      32'h80011234);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("hold_valid",     32'(core.rsp_valid), 32'd1);
      check("hold_rdata",     core.rsp_rdata,      32'h80011234);
      check("hold_req_ready", 32'(core.req_ready), 32'd0);
      check("hold_mem_en",    32'(sram.mem_en),    32'd0);
    end
    idle();
    core.rsp_ready = 1'b1;
    tick();
    check("hold_one_rsp",  32'(resp_cnt - cnt0), 32'd1);
    check("hold_drained",  32'(core.rsp_valid),  32'd0);

    cnt0 = resp_cnt;
    for (int i = 0; i < 8; i++) begin
      issue(14'((8 + i) * 4), 1'b0, SZ_W, 1'b0, 32'd0);
      tick();
      check("stream_rdata", core.rsp_rdata, 32'hA500_0000 | (8 + i));
    end
    check("stream_cnt8", 32'(resp_cnt - cnt0), 32'd7);
    idle();
    tick();
    check("stream_cnt9", 32'(resp_cnt - cnt0), 32'd8);
    check("stream_done", 32'(core.rsp_valid),  32'd0);

    issue(14'h002, 1'b0, SZ_W, 1'b0, 32'd0);
`ifdef DMEM_ERR_EN
    check("err_mem_en", 32'(sram.mem_en), 32'd0);
    tick();
    check("err_rsp_err",   32'(core.rsp_err), 32'd1);
    check("err_rsp_rdata", core.rsp_rdata,    32'd0);
`else
    check("mis_mem_en", 32'(sram.mem_en),   32'd1);
    check("mis_addr",   32'(sram.mem_addr), 32'd0);
    tick();
    check("mis_rsp_err",   32'(core.rsp_err), 32'd0);
    check("mis_rsp_rdata", core.rsp_rdata,    32'hA500_0000);
`endif
    idle();
    tick();

    issue(14'h010, 1'b0, SZ_W, 1'b0, 32'd0);
    tick();
    core.rsp_ready = 1'b0;
    idle();
    tick();
    check("prerst_valid", 32'(core.rsp_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_hold_valid", 32'(core.rsp_valid), 32'd0);
    check("rst_hold_rdata", core.rsp_rdata,      32'd0);
    tick();
    reset_n        = 1'b1;
    core.rsp_ready = 1'b1;
    #1;
    check("postrst_ready", 32'(core.req_ready), 32'd1);
    issue(14'h012, 1'b0, SZ_H, 1'b1, 32'd0);
    tick();
    check("postrst_lhu", core.rsp_rdata, 32'h00008001);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
